rom_loader: RTL
===============

Name: rom_loader

Overview:
- Writer side of the Hack instruction memory: receives a program as a byte stream and writes it, word by word, into the instruction RAM that the CPU fetches from (instruction = mem[pc]).
- Sits between a byte source (UART RX or SPI flash reader, valid/ready) and the instruction RAM write port.
- Holds the CPU in reset while loading and releases it once the image is complete.

Parameters:
- ADDR_W, 8, instruction RAM address width; depth DEPTH = 2**ADDR_W words (default 256).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- load_req  input  1  one-cycle pulse that starts a load
- rx_data  input  8  incoming byte
- rx_valid  input  1  rx_data valid this cycle
- rx_ready  output  1  loader accepts a byte this cycle
- wr_en  output  1  instruction RAM write strobe
- wr_addr  output  ADDR_W  instruction RAM write address
- wr_data  output  16  instruction word to write
- hold_cpu  output  1  keeps the CPU in reset
- busy  output  1  load in progress
- done  output  1  last load completed successfully (sticky)
- error  output  1  last load failed (sticky)

Behaviour:
- A byte transfer occurs when rx_valid and rx_ready are both 1 on a rising clk edge.
- Image format, all words big-endian (high byte first):
  - LEN: word count N, 1 <= N <= DEPTH.
  - N instruction words.
  - With CHECKSUM_EN only: a trailing checksum word.
- Reset (async, immediate) forces: state IDLE, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, error=0, rx_ready=0, hold_cpu=1.
  - The CPU stays held until the first successful load.
- States and transitions:
  - IDLE: rx_ready=0. On load_req: go to LEN_HI, clear done/error, busy=1, hold_cpu=1, word counter=0.
  - LEN_HI: rx_ready=1. On a byte, latch the high byte of N and go to LEN_LO.
  - LEN_LO: rx_ready=1. On a byte, complete N.
    - N==0 or N>DEPTH: go to ERROR.
    - Otherwise: go to DAT_HI.
  - DAT_HI: rx_ready=1. On a byte, latch the high byte and go to DAT_LO.
  - DAT_LO: rx_ready=1. On a byte:
    - Next cycle: wr_en=1 for exactly one cycle, with wr_data={hi,lo} and wr_addr = word counter.
    - The counter increments after the write.
    - When counter+1==N, go to FINISH (or CSUM_HI with CHECKSUM_EN); otherwise go back to DAT_HI.
  - FINISH: one cycle after the final write completes. Then done=1, busy=0, hold_cpu=0, go to IDLE.
  - ERROR: error=1, busy=0, hold_cpu=1, go to IDLE.
- Write latency: exactly 1 cycle from the accepted low byte to wr_en. wr_addr/wr_data are stable while wr_en=1.
- wr_addr counts 0..N-1 and never wraps. N=DEPTH writes address DEPTH-1 last; the internal counter is ADDR_W+1 bits wide.
- rx_ready is deasserted in IDLE, FINISH, ERROR and during the wr_en cycle. Bytes offered then are not consumed.
- load_req while busy=1 is ignored; the current load continues.
- load_req in IDLE after done or error starts a fresh load from address 0.
- Reset mid-load aborts immediately. Already-written RAM words are left as they are. done=0, hold_cpu=1.
- rx_valid without a transfer (rx_ready=0) has no effect.

Optional Feature:
- Macro: ROM_LOADER_CHECKSUM_EN.
- Defined:
  - Keeps a 16-bit running sum (mod 2**16) of the N data words; LEN is not included.
  - After the last data word, states CSUM_HI/CSUM_LO receive the checksum word.
  - Match: go to FINISH (done=1, CPU released).
  - Mismatch: go to ERROR (error=1, hold_cpu stays 1).
  - Data words are written during reception regardless of the checksum outcome.
- Not defined:
  - No checksum word is expected and no checksum logic is present.
  - Completion happens right after the Nth write; the state goes straight to FINISH.

Test Plan:
- Reset, then idle 10 cycles -> hold_cpu=1, busy=0, done=0, error=0, rx_ready=0, wr_en never asserted.
- load_req, then bytes 00 03 | 12 34 | AB CD | FF FF -> exactly three one-cycle wr_en pulses:
  - (addr 0, 1234), (addr 1, ABCD), (addr 2, FFFF);
  - then done=1, hold_cpu=0, busy=0.
- Length errors:
  - LEN = 00 00 -> error=1, no writes, hold_cpu=1.
  - LEN = 01 01 (257 > 256) -> error=1, no writes.
- Full depth: LEN = 01 00, words 0x0000..0x00FF -> 256 writes, last at addr 255 with data 00FF, done=1.
- Mid-load interruptions:
  - load_req mid-load after 1 word -> ignored; the load completes normally.
  - Reset asserted after 2 of 5 words -> outputs return to reset values immediately.
  - A new load_req then writes starting at addr 0.
- ROM_LOADER_CHECKSUM_EN with image 00 02 | 00 10 | 00 20:
  - Checksum 00 30 -> done=1.
  - Checksum 00 31 -> error=1, hold_cpu=1, both data writes still occurred.
- Backpressure: rx_valid held high continuously -> no byte consumed in the wr_en cycles, and the byte count matches the image exactly.

Source files
------------

// File: rtl/rom_loader.sv
// Byte-stream loader for the Hack instruction RAM; ROM_LOADER_CHECKSUM_EN adds a trailing checksum word.
// Latency: wr_en one cycle after the accepted low byte. Backpressure: rx_ready low outside byte states and during wr_en.
module rom_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_req,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              hold_cpu,
  output logic              busy,
  output logic              done,
  output logic              error
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DAT_HI,
    S_DAT_LO,
    S_WR,
`ifdef ROM_LOADER_CHECKSUM_EN
    S_CSUM_HI,
    S_CSUM_LO,
`endif
    S_FINISH,
    S_ERROR
  } state_t;

  state_t            state, state_nx;
  logic [7:0]        hi_q;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   cnt_q;
  logic [ADDR_W:0]   cnt_inc;
  logic [15:0]       byte_pair;
  logic              xfer;
  logic              len_bad;
  logic              last_word;
`ifdef ROM_LOADER_CHECKSUM_EN
  logic [15:0]       sum_q;
`endif

  assign byte_pair = {hi_q, rx_data};
  assign len_bad   = (byte_pair == 16'd0) || (32'(byte_pair) > 32'(DEPTH));
  assign cnt_inc   = cnt_q + {{ADDR_W{1'b0}}, 1'b1};
  assign last_word = (cnt_inc == len_q);
  assign xfer      = rx_valid && rx_ready;
  assign wr_en     = (state == S_WR);
  assign wr_addr   = cnt_q[ADDR_W-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    rx_ready = 1'b0;
    case (state)
      S_IDLE:   if (load_req) state_nx = S_LEN_HI;
      S_LEN_HI: begin
        rx_ready = 1'b1;
        if (xfer) state_nx = S_LEN_LO;
      end
      S_LEN_LO: begin
        rx_ready = 1'b1;
        if (xfer) state_nx = len_bad ? S_ERROR : S_DAT_HI;
      end
      S_DAT_HI: begin
        rx_ready = 1'b1;
        if (xfer) state_nx = S_DAT_LO;
      end
      S_DAT_LO: begin
        rx_ready = 1'b1;
        if (xfer) state_nx = S_WR;
      end
`ifdef ROM_LOADER_CHECKSUM_EN
      S_WR:     state_nx = last_word ? S_CSUM_HI : S_DAT_HI;
      S_CSUM_HI: begin
        rx_ready = 1'b1;
        if (xfer) state_nx = S_CSUM_LO;
      end
      S_CSUM_LO: begin
        rx_ready = 1'b1;
        if (xfer) state_nx = (byte_pair == sum_q) ? S_FINISH : S_ERROR;
      end
`else
      S_WR:     state_nx = last_word ? S_FINISH : S_DAT_HI;
`endif
      S_FINISH: state_nx = S_IDLE;
      S_ERROR:  state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Datapath and sticky status; hold_cpu only drops after a fully accepted image.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q     <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      wr_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      hold_cpu <= 1'b1;
`ifdef ROM_LOADER_CHECKSUM_EN
      sum_q    <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: if (load_req) begin
          done     <= 1'b0;
          error    <= 1'b0;
          busy     <= 1'b1;
          hold_cpu <= 1'b1;
          cnt_q    <= '0;
`ifdef ROM_LOADER_CHECKSUM_EN
          sum_q    <= '0;
`endif
        end
        S_LEN_HI: if (xfer) hi_q <= rx_data;
        S_LEN_LO: if (xfer) len_q <= byte_pair[ADDR_W:0];
        S_DAT_HI: if (xfer) hi_q <= rx_data;
        S_DAT_LO: if (xfer) begin
          wr_data <= byte_pair;
`ifdef ROM_LOADER_CHECKSUM_EN
          sum_q   <= sum_q + byte_pair;
`endif
        end
        S_WR: cnt_q <= cnt_inc;
`ifdef ROM_LOADER_CHECKSUM_EN
        S_CSUM_HI: if (xfer) hi_q <= rx_data;
`endif
        S_FINISH: begin
          done     <= 1'b1;
          busy     <= 1'b0;
          hold_cpu <= 1'b0;
        end
        S_ERROR: begin
          error    <= 1'b1;
          busy     <= 1'b0;
          hold_cpu <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
